// File: rtl/au_seq_ctrl.sv
// Command sequencer for the 8-bit AU: one command per handshake, done pulses one cycle after completion (DIV: q+1 cycles).
// cmd_ready is high only in IDLE; build with AU_SEQ_CTRL_DIV_EN for the repeated-subtract DIV loop, else op 101 is illegal.
module au_seq_ctrl #(
  parameter int DW  = 8,
  parameter int RAW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [2:0]     cmd_op,
  input  logic [RAW-1:0] cmd_rd,
  input  logic [RAW-1:0] cmd_rs,
  input  logic [DW-1:0]  cmd_imm,
  output logic           done,
  output logic           err,
  output logic           gf_flag,
  output logic           au_en,
  output logic [3:0]     au_ac,
  output logic [DW-1:0]  au_a,
  output logic [DW-1:0]  au_b,
  input  logic [DW-1:0]  au_t,
  input  logic           au_gf,
  input  logic [RAW-1:0] dbg_sel,
  output logic [DW-1:0]  dbg_data
);

  localparam int NREG = 2 ** RAW;
  localparam logic [RAW-1:0] LAST = RAW'(NREG - 1);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_MOV = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;

`ifdef AU_SEQ_CTRL_DIV_EN
  localparam logic [2:0] OP_DIV = 3'b101;
  typedef enum logic [1:0] {IDLE, EXEC, DIVL} state_t;
`else
  typedef enum logic [0:0] {IDLE, EXEC} state_t;
`endif

  state_t                       state_q, state_d;
  logic [2:0]                   op_q, op_d;
  logic [RAW-1:0]               rd_q, rd_d, rs_q, rs_d;
  logic [DW-1:0]                imm_q, imm_d;
  logic [NREG-1:0][DW-1:0]      rf_q, rf_d;
  logic                         gf_q, gf_d, done_q, done_d, err_q, err_d;
`ifdef AU_SEQ_CTRL_DIV_EN
  logic [DW-1:0]                dvs_q, dvs_d, rem_q, rem_d, q_q, q_d;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign gf_flag   = gf_q;
  assign dbg_data  = rf_q[dbg_sel];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    imm_d   = imm_q;
    rf_d    = rf_q;
    gf_d    = gf_q;
    done_d  = 1'b0;
    err_d   = err_q;
    au_en   = 1'b0;
    au_ac   = 4'b0000;
    au_a    = '0;
    au_b    = '0;
`ifdef AU_SEQ_CTRL_DIV_EN
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    q_d     = q_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          rd_d    = cmd_rd;
          rs_d    = cmd_rs;
          imm_d   = cmd_imm;
          err_d   = 1'b0;
          state_d = EXEC;
`ifdef AU_SEQ_CTRL_DIV_EN
          if (cmd_op == OP_DIV) begin
            state_d = DIVL;
            rem_d   = rf_q[cmd_rd];
            dvs_d   = rf_q[cmd_rs];
            q_d     = '0;
          end
`endif
        end
      end
      EXEC: begin
        // Operands come from rf_q, so rd==rs reads the old value before writeback.
        case (op_q)
          OP_NOP: ;
          OP_LDI: rf_d[rd_q] = imm_q;
          OP_MOV: begin
            au_en      = 1'b1;
            au_ac      = 4'b0100;
            au_a       = rf_q[rs_q];
            rf_d[rd_q] = au_t;
          end
          OP_ADD: begin
            au_en      = 1'b1;
            au_ac      = 4'b1000;
            au_a       = rf_q[rs_q];
            au_b       = rf_q[rd_q];
            rf_d[rd_q] = au_t;
          end
          OP_SUB: begin
            au_en      = 1'b1;
            au_ac      = 4'b1001;
            au_a       = rf_q[rs_q];
            au_b       = rf_q[rd_q];
            rf_d[rd_q] = au_t;
            gf_d       = au_gf;
          end
          default: err_d = 1'b1;
        endcase
        state_d = IDLE;
        done_d  = 1'b1;
      end
`ifdef AU_SEQ_CTRL_DIV_EN
      DIVL: begin
        if (dvs_q == '0) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          au_en = 1'b1;
          au_ac = 4'b1001;
          au_a  = dvs_q;
          au_b  = rem_q;
          // rem >= dvs: either strictly greater (gf) or an exact zero difference.
          if (au_gf || (au_t == '0)) begin
            rem_d = au_t;
            q_d   = q_q + DW'(1);
          end else begin
            rf_d[LAST] = rem_q;
            rf_d[rd_q] = q_q;
            done_d     = 1'b1;
            state_d    = IDLE;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      imm_q   <= '0;
      rf_q    <= '0;
      gf_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef AU_SEQ_CTRL_DIV_EN
      dvs_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      imm_q   <= imm_d;
      rf_q    <= rf_d;
      gf_q    <= gf_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef AU_SEQ_CTRL_DIV_EN
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
`endif
    end
  end

endmodule

// File: tb/tb_au_seq_ctrl.sv
// Directed vector bench for au_seq_ctrl with a behavioural AU model; DIV vectors apply when AU_SEQ_CTRL_DIV_EN is defined.
module tb_au_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [1:0] cmd_rd = '0, cmd_rs = '0;
  logic [7:0] cmd_imm = '0;
  logic       done, err, gf_flag, au_en;
  logic [3:0] au_ac;
  logic [7:0] au_a, au_b, au_t;
  logic       au_gf;
  logic [1:0] dbg_sel = '0;
  logic [7:0] dbg_data;
  logic [7:0] au_res;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  au_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_imm(cmd_imm),
    .done(done), .err(err), .gf_flag(gf_flag), .au_en(au_en), .au_ac(au_ac),
    .au_a(au_a), .au_b(au_b), .au_t(au_t), .au_gf(au_gf),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // AU model: MOV passes a, ADD a+b, SUB b-a with gf = b>a; A5 stands in for the undriven bus.
  always_comb begin
    au_res = 8'h00;
    case (au_ac)
      4'b0100: au_res = au_a;
      4'b1000: au_res = au_a + au_b;
      4'b1001: au_res = au_b - au_a;
      default: au_res = 8'h00;
    endcase
  end
  assign au_t  = au_en ? au_res : 8'hA5;
  assign au_gf = au_en && (au_ac == 4'b1001) && (au_b > au_a);

  typedef struct {
    logic [2:0] op;
    logic [1:0] rd, rs;
    logic [7:0] imm;
    logic       en;
    logic [3:0] ac;
    logic [7:0] a, b;
    int         lat, encnt;
    logic [1:0] s1;
    logic [7:0] e1;
    logic [1:0] s2;
    logic [7:0] e2;
    logic       e_err, e_gf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic [2:0] op, logic [1:0] rd, logic [1:0] rs, logic [7:0] imm,
                             logic en, logic [3:0] ac, logic [7:0] a, logic [7:0] b,
                             int lat, int encnt, logic [1:0] s1, logic [7:0] e1,
                             logic [1:0] s2, logic [7:0] e2, logic e_err, logic e_gf);
    vec_t r;
    r.op = op; r.rd = rd; r.rs = rs; r.imm = imm; r.en = en; r.ac = ac; r.a = a; r.b = b;
    r.lat = lat; r.encnt = encnt; r.s1 = s1; r.e1 = e1; r.s2 = s2; r.e2 = e2;
    r.e_err = e_err; r.e_gf = e_gf;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reg(input string nm, input logic [1:0] sel, input logic [7:0] exp);
    dbg_sel = sel;
    #1;
    chk($sformatf("%s_R%0d", nm, sel), {24'h0, dbg_data}, {24'h0, exp});
  endtask

  task automatic run_vec(input int idx, input vec_t t);
    int lat, encnt;
    string nm;
    nm = $sformatf("v%0d", idx);
    chk({nm, "_ready_pre"}, {31'h0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = t.op; cmd_rd = t.rd; cmd_rs = t.rs; cmd_imm = t.imm;
    @(posedge clk); #1;
    // Junk held on the bus while busy must never be accepted.
    cmd_op = 3'b001; cmd_imm = 8'hEE;
    chk({nm, "_au_en"}, {31'h0, au_en}, {31'h0, t.en});
    if (t.en) begin
      chk({nm, "_au_ac"}, {28'h0, au_ac}, {28'h0, t.ac});
      chk({nm, "_au_a"}, {24'h0, au_a}, {24'h0, t.a});
      chk({nm, "_au_b"}, {24'h0, au_b}, {24'h0, t.b});
    end
    lat = 0; encnt = 0;
    while (lat < 300) begin
      if (au_en) encnt++;
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    chk({nm, "_latency"}, lat, t.lat);
    chk({nm, "_en_cycles"}, encnt, t.encnt);
    chk({nm, "_ready_done"}, {31'h0, cmd_ready}, 32'd1);
    chk({nm, "_err"}, {31'h0, err}, {31'h0, t.e_err});
    chk({nm, "_gf"}, {31'h0, gf_flag}, {31'h0, t.e_gf});
    cmd_valid = 1'b0;
    chk_reg(nm, t.s1, t.e1);
    chk_reg(nm, t.s2, t.e2);
  endtask

  initial begin
    // op, rd, rs, imm, en, ac, a, b, lat, encnt, s1, e1, s2, e2, err, gf
    vecs.push_back(v(3'b001, 2'd1, 2'd0, 8'h05, 0, 4'h0, 8'h00, 8'h00, 1, 0, 2'd1, 8'h05, 2'd0, 8'h00, 0, 0));
    vecs.push_back(v(3'b001, 2'd2, 2'd0, 8'h03, 0, 4'h0, 8'h00, 8'h00, 1, 0, 2'd2, 8'h03, 2'd1, 8'h05, 0, 0));
    vecs.push_back(v(3'b011, 2'd1, 2'd2, 8'h00, 1, 4'h8, 8'h03, 8'h05, 1, 1, 2'd1, 8'h08, 2'd2, 8'h03, 0, 0));
    vecs.push_back(v(3'b100, 2'd2, 2'd1, 8'h00, 1, 4'h9, 8'h08, 8'h03, 1, 1, 2'd2, 8'hFB, 2'd1, 8'h08, 0, 0));
    vecs.push_back(v(3'b001, 2'd2, 2'd0, 8'h03, 0, 4'h0, 8'h00, 8'h00, 1, 0, 2'd2, 8'h03, 2'd1, 8'h08, 0, 0));
    vecs.push_back(v(3'b100, 2'd1, 2'd2, 8'h00, 1, 4'h9, 8'h03, 8'h08, 1, 1, 2'd1, 8'h05, 2'd2, 8'h03, 0, 1));
    vecs.push_back(v(3'b010, 2'd0, 2'd1, 8'h00, 1, 4'h4, 8'h05, 8'h00, 1, 1, 2'd0, 8'h05, 2'd1, 8'h05, 0, 1));
    vecs.push_back(v(3'b011, 2'd0, 2'd0, 8'h00, 1, 4'h8, 8'h05, 8'h05, 1, 1, 2'd0, 8'h0A, 2'd1, 8'h05, 0, 1));
    vecs.push_back(v(3'b001, 2'd3, 2'd0, 8'hFF, 0, 4'h0, 8'h00, 8'h00, 1, 0, 2'd3, 8'hFF, 2'd0, 8'h0A, 0, 1));
    vecs.push_back(v(3'b011, 2'd3, 2'd1, 8'h00, 1, 4'h8, 8'h05, 8'hFF, 1, 1, 2'd3, 8'h04, 2'd1, 8'h05, 0, 1));
    vecs.push_back(v(3'b111, 2'd0, 2'd1, 8'h77, 0, 4'h0, 8'h00, 8'h00, 1, 0, 2'd0, 8'h0A, 2'd3, 8'h04, 1, 1));
    vecs.push_back(v(3'b000, 2'd1, 2'd0, 8'h00, 0, 4'h0, 8'h00, 8'h00, 1, 0, 2'd1, 8'h05, 2'd0, 8'h0A, 0, 1));
    vecs.push_back(v(3'b110, 2'd2, 2'd0, 8'h99, 0, 4'h0, 8'h00, 8'h00, 1, 0, 2'd2, 8'h03, 2'd1, 8'h05, 1, 1));
    vecs.push_back(v(3'b100, 2'd0, 2'd0, 8'h00, 1, 4'h9, 8'h0A, 8'h0A, 1, 1, 2'd0, 8'h00, 2'd1, 8'h05, 0, 0));
    vecs.push_back(v(3'b100, 2'd3, 2'd2, 8'h00, 1, 4'h9, 8'h03, 8'h04, 1, 1, 2'd3, 8'h01, 2'd2, 8'h03, 0, 1));
`ifdef AU_SEQ_CTRL_DIV_EN
    vecs.push_back(v(3'b001, 2'd0, 2'd0, 8'h07, 0, 4'h0, 8'h00, 8'h00, 1, 0, 2'd0, 8'h07, 2'd3, 8'h01, 0, 1));
    vecs.push_back(v(3'b001, 2'd1, 2'd0, 8'h02, 0, 4'h0, 8'h00, 8'h00, 1, 0, 2'd1, 8'h02, 2'd0, 8'h07, 0, 1));
    vecs.push_back(v(3'b101, 2'd0, 2'd1, 8'h00, 1, 4'h9, 8'h02, 8'h07, 4, 4, 2'd0, 8'h03, 2'd3, 8'h01, 0, 1));
    vecs.push_back(v(3'b001, 2'd0, 2'd0, 8'h05, 0, 4'h0, 8'h00, 8'h00, 1, 0, 2'd0, 8'h05, 2'd3, 8'h01, 0, 1));
    vecs.push_back(v(3'b001, 2'd1, 2'd0, 8'h05, 0, 4'h0, 8'h00, 8'h00, 1, 0, 2'd1, 8'h05, 2'd0, 8'h05, 0, 1));
    vecs.push_back(v(3'b101, 2'd0, 2'd1, 8'h00, 1, 4'h9, 8'h05, 8'h05, 2, 2, 2'd0, 8'h01, 2'd3, 8'h00, 0, 1));
    vecs.push_back(v(3'b001, 2'd0, 2'd0, 8'h00, 0, 4'h0, 8'h00, 8'h00, 1, 0, 2'd0, 8'h00, 2'd1, 8'h05, 0, 1));
    vecs.push_back(v(3'b101, 2'd0, 2'd1, 8'h00, 1, 4'h9, 8'h05, 8'h00, 1, 1, 2'd0, 8'h00, 2'd3, 8'h00, 0, 1));
    vecs.push_back(v(3'b001, 2'd3, 2'd0, 8'h3C, 0, 4'h0, 8'h00, 8'h00, 1, 0, 2'd3, 8'h3C, 2'd0, 8'h00, 0, 1));
    vecs.push_back(v(3'b001, 2'd0, 2'd0, 8'h07, 0, 4'h0, 8'h00, 8'h00, 1, 0, 2'd0, 8'h07, 2'd3, 8'h3C, 0, 1));
    vecs.push_back(v(3'b001, 2'd1, 2'd0, 8'h00, 0, 4'h0, 8'h00, 8'h00, 1, 0, 2'd1, 8'h00, 2'd0, 8'h07, 0, 1));
    vecs.push_back(v(3'b101, 2'd0, 2'd1, 8'h00, 0, 4'h0, 8'h00, 8'h00, 1, 0, 2'd0, 8'h07, 2'd3, 8'h3C, 1, 1));
    vecs.push_back(v(3'b001, 2'd3, 2'd0, 8'h09, 0, 4'h0, 8'h00, 8'h00, 1, 0, 2'd3, 8'h09, 2'd0, 8'h07, 0, 1));
    vecs.push_back(v(3'b001, 2'd1, 2'd0, 8'h04, 0, 4'h0, 8'h00, 8'h00, 1, 0, 2'd1, 8'h04, 2'd3, 8'h09, 0, 1));
    vecs.push_back(v(3'b101, 2'd3, 2'd1, 8'h00, 1, 4'h9, 8'h04, 8'h09, 3, 3, 2'd3, 8'h02, 2'd0, 8'h07, 0, 1));
    vecs.push_back(v(3'b001, 2'd0, 2'd0, 8'hC8, 0, 4'h0, 8'h00, 8'h00, 1, 0, 2'd0, 8'hC8, 2'd3, 8'h02, 0, 1));
    vecs.push_back(v(3'b001, 2'd1, 2'd0, 8'h01, 0, 4'h0, 8'h00, 8'h00, 1, 0, 2'd1, 8'h01, 2'd0, 8'hC8, 0, 1));
`else
    vecs.push_back(v(3'b101, 2'd0, 2'd1, 8'h00, 0, 4'h0, 8'h00, 8'h00, 1, 0, 2'd0, 8'h00, 2'd3, 8'h01, 1, 1));
`endif

    #2;
    chk("rst_ready", {31'h0, cmd_ready}, 32'd1);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_err", {31'h0, err}, 32'd0);
    chk("rst_gf", {31'h0, gf_flag}, 32'd0);
    chk("rst_au_en", {31'h0, au_en}, 32'd0);
    for (int r = 0; r < 4; r++) chk_reg("rst", 2'(r), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset while the AU is busy: au_en must drop with no clock edge.
    cmd_valid = 1'b1; cmd_op = 3'b011; cmd_rd = 2'd0; cmd_rs = 2'd1;
`ifdef AU_SEQ_CTRL_DIV_EN
    cmd_op = 3'b101;
`endif
    @(posedge clk); #1;
    cmd_valid = 1'b0;
`ifdef AU_SEQ_CTRL_DIV_EN
    repeat (3) begin @(posedge clk); #1; end
`endif
    chk("midop_au_en_busy", {31'h0, au_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midop_au_en_rst", {31'h0, au_en}, 32'd0);
    chk("midop_gf_rst", {31'h0, gf_flag}, 32'd0);
    chk("midop_done_rst", {31'h0, done}, 32'd0);
    for (int r = 0; r < 4; r++) chk_reg("midop", 2'(r), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midop_ready_after", {31'h0, cmd_ready}, 32'd1);
    chk("midop_done_after", {31'h0, done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
